// File: rtl/exec_cdb_pkg.sv
// exec_cdb_pkg: shared widths, CDB entry layout and output-register states for exec_cdb_arbiter
package exec_cdb_pkg;
  localparam int VAL_W = 64;
  localparam int CMD_W = 10;
  localparam int FLAG_W = 4;
  localparam int TAG_MAX_W = 8;
  localparam int SRC_MAX_W = 8;
  typedef enum logic [1:0] {CDB_IDLE, CDB_HOLD, CDB_FLOW} cdb_state_e;
  // tag/src sized for the widest build; the top slices to its parameterised widths
  typedef struct packed {
    logic [VAL_W-1:0] val;
    logic [CMD_W-1:0] commands;
    logic [TAG_MAX_W-1:0] tag;
    logic [FLAG_W-1:0] flags;
    logic [SRC_MAX_W-1:0] src;
  } cdb_entry_t;
endpackage

// File: rtl/exec_cdb_arbiter_if.sv
// exec_cdb_arbiter_if: execute-unit results in, one-hot grants out, CDB toward ROB/RS with backpressure
interface exec_cdb_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int TAG_W = 4
);
  import exec_cdb_pkg::*;
  localparam int SRC_W = $clog2(NUM_UNITS);
  logic [NUM_UNITS-1:0] unitValid_i;
  logic [NUM_UNITS*VAL_W-1:0] unitVal_i;
  logic [NUM_UNITS*CMD_W-1:0] unitCommands_i;
  logic [NUM_UNITS*TAG_W-1:0] unitTag_i;
  logic [NUM_UNITS*FLAG_W-1:0] unitFlags_i;
  logic [NUM_UNITS-1:0] canGo_o;
  logic cdbValid_o;
  logic [VAL_W-1:0] cdbVal_o;
  logic [CMD_W-1:0] cdbCommands_o;
  logic [TAG_W-1:0] cdbTag_o;
  logic [FLAG_W-1:0] cdbFlags_o;
  logic [SRC_W-1:0] cdbSrc_o;
  logic cdbReady_i;
  modport slave (
    input unitValid_i, unitVal_i, unitCommands_i, unitTag_i, unitFlags_i, cdbReady_i,
    output canGo_o, cdbValid_o, cdbVal_o, cdbCommands_o, cdbTag_o, cdbFlags_o, cdbSrc_o
  );
  modport master (
    output unitValid_i, unitVal_i, unitCommands_i, unitTag_i, unitFlags_i, cdbReady_i,
    input canGo_o, cdbValid_o, cdbVal_o, cdbCommands_o, cdbTag_o, cdbFlags_o, cdbSrc_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr_i, with wrap
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input logic [N-1:0] req_i,
  input logic [IW-1:0] ptr_i,
  input logic en_i,
  output logic [N-1:0] grant_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] k;
  // walk offsets from farthest to nearest so the nearest requester is the last one written
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr_i) + i) % N);
      if (en_i && req_i[k]) begin
        grant_o = '0;
        grant_o[k] = 1'b1;
        idx_o = k;
      end
    end
  end
endmodule

// File: rtl/exec_cdb_arbiter.sv
// exec_cdb_arbiter: round-robin collection of execute results onto a registered, backpressured CDB.
// Build option EXEC_CDB_PERF_CNT_EN adds saturating conflict/stall counters.
module exec_cdb_arbiter
  import exec_cdb_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int ROBsize = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input logic clk_i,
  input logic reset_i,
  exec_cdb_arbiter_if.slave bus
`ifdef EXEC_CDB_PERF_CNT_EN
  ,
  output logic [31:0] perfConflict_o,
  output logic [31:0] perfStall_o
`endif
);
  localparam int IW = $clog2(NUM_UNITS);
  logic load, any, valid_q, valid_d, unused_bits;
  logic [NUM_UNITS-1:0] grant;
  logic [IW-1:0] idx, rr_q, rr_d;
  cdb_entry_t entry_q, entry_d;
  cdb_state_e state;
  assign load = ~valid_q | bus.cdbReady_i;
  rr_arbiter #(.N(NUM_UNITS)) u_rr (
    .req_i(bus.unitValid_i),
    .ptr_i(rr_q),
    .en_i(load & ~reset_i),
    .grant_o(grant),
    .idx_o(idx)
  );
  assign any = |grant;
  always_comb begin
    state = !valid_q ? CDB_IDLE : bus.cdbReady_i ? CDB_FLOW : CDB_HOLD;
    valid_d = state == CDB_HOLD ? valid_q : any;
    entry_d = any ? '{val: bus.unitVal_i[int'(idx)*VAL_W +: VAL_W],
                      commands: bus.unitCommands_i[int'(idx)*CMD_W +: CMD_W],
                      tag: TAG_MAX_W'(bus.unitTag_i[int'(idx)*ROBsizeLog +: ROBsizeLog]),
                      flags: bus.unitFlags_i[int'(idx)*FLAG_W +: FLAG_W],
                      src: SRC_MAX_W'(idx)} : entry_q;
    rr_d = any ? (idx == IW'(NUM_UNITS - 1) ? '0 : idx + 1'b1) : rr_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
      rr_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
      rr_q <= rr_d;
    end
  end
  assign bus.canGo_o = grant;
  assign bus.cdbValid_o = valid_q;
  assign bus.cdbVal_o = entry_q.val;
  assign bus.cdbCommands_o = entry_q.commands;
  assign bus.cdbTag_o = entry_q.tag[ROBsizeLog-1:0];
  assign bus.cdbFlags_o = entry_q.flags;
  assign bus.cdbSrc_o = entry_q.src[IW-1:0];
  assign unused_bits = ^entry_q;
`ifdef EXEC_CDB_PERF_CNT_EN
  logic [31:0] conf_q, stall_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      conf_q <= '0;
      stall_q <= '0;
    end else begin
      if ($countones(bus.unitValid_i) > 1 && conf_q != '1) conf_q <= conf_q + 32'd1;
      if (state == CDB_HOLD && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end
  assign perfConflict_o = conf_q;
  assign perfStall_o = stall_q;
`endif
endmodule

// File: tb/tb_exec_cdb_arbiter.sv
// tb_exec_cdb_arbiter: directed vectors plus a per-cycle reference model of the CDB arbiter.
// Also checks the counters when EXEC_CDB_PERF_CNT_EN is defined.
module tb_exec_cdb_arbiter;
  import exec_cdb_pkg::*;
  localparam int N = 4;
  localparam int TW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  exec_cdb_arbiter_if #(.NUM_UNITS(N), .TAG_W(TW)) bus ();
`ifdef EXEC_CDB_PERF_CNT_EN
  logic [31:0] perf_conf, perf_stall;
`endif
  exec_cdb_arbiter #(.NUM_UNITS(N), .ROBsize(8)) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus)
`ifdef EXEC_CDB_PERF_CNT_EN
    ,
    .perfConflict_o(perf_conf),
    .perfStall_o(perf_stall)
`endif
  );
  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit m_valid = 0;
  int m_rr = 0;
  int m_src = 0;
  int m_conf = 0;
  int m_stall = 0;
  logic [63:0] m_val = '0;
  logic [9:0] m_cmd = '0;
  logic [TW-1:0] m_tag = '0;
  logic [3:0] m_flags = '0;
  logic [N-1:0] gnt_seen = '0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // reference: the winner is the nearest requester at or after the pointer, only when the CDB can load
  always @(negedge clk) begin : model
    logic [N-1:0] eg;
    bit load;
    int w;
    eg = '0;
    w = -1;
    load = !m_valid || bus.cdbReady_i;
    if (!rst && load)
      for (int j = 0; j < N; j++)
        if (w < 0 && ((bus.unitValid_i >> ((m_rr + j) % N)) & N'(1)) != '0) w = (m_rr + j) % N;
    if (w >= 0) eg = N'(1) << w;
    if (started) begin
      chk("m_canGo", 64'(bus.canGo_o), 64'(eg));
      chk("m_cdbValid", 64'(bus.cdbValid_o), 64'(m_valid));
      if (m_valid) begin
        chk("m_cdbVal", bus.cdbVal_o, m_val);
        chk("m_cdbCmd", 64'(bus.cdbCommands_o), 64'(m_cmd));
        chk("m_cdbTag", 64'(bus.cdbTag_o), 64'(m_tag));
        chk("m_cdbFlags", 64'(bus.cdbFlags_o), 64'(m_flags));
        chk("m_cdbSrc", 64'(bus.cdbSrc_o), 64'(m_src));
      end
`ifdef EXEC_CDB_PERF_CNT_EN
      chk("m_perfConflict", 64'(perf_conf), 64'(m_conf));
      chk("m_perfStall", 64'(perf_stall), 64'(m_stall));
`endif
    end
    gnt_seen = bus.canGo_o;
    if (rst) begin
      m_conf = 0;
      m_stall = 0;
    end else begin
      if ($countones(bus.unitValid_i) > 1) m_conf++;
      if (m_valid && !bus.cdbReady_i) m_stall++;
    end
    if (rst) begin
      m_valid = 0;
      m_rr = 0;
      started = 1;
    end else if (load) begin
      m_valid = w >= 0;
      if (w >= 0) begin
        m_val = bus.unitVal_i[w*64 +: 64];
        m_cmd = bus.unitCommands_i[w*10 +: 10];
        m_tag = bus.unitTag_i[w*TW +: TW];
        m_flags = bus.unitFlags_i[w*4 +: 4];
        m_src = w;
        m_rr = (w + 1) % N;
      end
    end
  end
  // a unit drops its valid right after the edge following its grant
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.unitValid_i = bus.unitValid_i & ~gnt_seen;
    end
  endtask
  task automatic set_unit(input int k, input logic [63:0] v, input logic [TW-1:0] t);
    bus.unitVal_i[k*64 +: 64] = v;
    bus.unitCommands_i[k*10 +: 10] = v[9:0];
    bus.unitTag_i[k*TW +: TW] = t;
    bus.unitFlags_i[k*4 +: 4] = t ^ 4'hA;
  endtask
  initial begin
    bus.unitValid_i = '0;
    bus.unitVal_i = '0;
    bus.unitCommands_i = '0;
    bus.unitTag_i = '0;
    bus.unitFlags_i = '0;
    bus.cdbReady_i = 1'b1;
    cyc(1);
    bus.unitValid_i = '1;
    #2 chk("reset_canGo", 64'(bus.canGo_o), 64'd0);
    cyc(1);
    chk("reset_cdbValid", 64'(bus.cdbValid_o), 64'd0);
    bus.unitValid_i = '0;
    rst = 1'b0;
    set_unit(0, 64'h1234, 4'd3);
    bus.unitValid_i = 4'b0001;
    #2 chk("single_canGo", 64'(bus.canGo_o), 64'h1);
    cyc(1);
    chk("single_valid", 64'(bus.cdbValid_o), 64'd1);
    chk("single_val", bus.cdbVal_o, 64'h1234);
    chk("single_tag", 64'(bus.cdbTag_o), 64'd3);
    chk("single_src", 64'(bus.cdbSrc_o), 64'd0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int k = 0; k < N; k++) set_unit(k, 64'hA000 + 64'(k), 4'(k + 4));
    bus.unitValid_i = 4'b1111;
    for (int i = 0; i < N; i++) begin
      #2 chk("all_canGo", 64'(bus.canGo_o), 64'(1) << i);
      cyc(1);
      chk("all_src", 64'(bus.cdbSrc_o), 64'(i));
      chk("all_val", bus.cdbVal_o, 64'hA000 + 64'(i));
    end
    cyc(1);
    chk("drain_valid", 64'(bus.cdbValid_o), 64'd0);
    bus.unitValid_i = 4'b0001;
    cyc(1);
    bus.cdbReady_i = 1'b0;
    bus.unitValid_i = 4'b0110;
    repeat (5) begin
      #2 chk("stall_canGo", 64'(bus.canGo_o), 64'd0);
      chk("stall_val", bus.cdbVal_o, 64'hA000);
      cyc(1);
    end
    bus.cdbReady_i = 1'b1;
    #2 chk("release_canGo", 64'(bus.canGo_o), 64'b0010);
    cyc(1);
    chk("release_src", 64'(bus.cdbSrc_o), 64'd1);
    #2 chk("release2_canGo", 64'(bus.canGo_o), 64'b0100);
    cyc(1);
    chk("release2_src", 64'(bus.cdbSrc_o), 64'd2);
    bus.unitValid_i = 4'b1000;
    cyc(1);
    bus.unitValid_i = 4'b1001;
    #2 chk("wrap_first", 64'(bus.canGo_o), 64'b0001);
    cyc(1);
    #2 chk("wrap_second", 64'(bus.canGo_o), 64'b1000);
    cyc(1);
    chk("wrap_src", 64'(bus.cdbSrc_o), 64'd3);
    chk("wrap_val", bus.cdbVal_o, 64'hA003);
    bus.unitValid_i = 4'b0010;
    cyc(1);
    bus.cdbReady_i = 1'b0;
    bus.unitValid_i = 4'b0100;
    cyc(1);
    chk("midrst_before", 64'(bus.cdbValid_o), 64'd1);
    rst = 1'b1;
    #2 chk("midrst_canGo", 64'(bus.canGo_o), 64'd0);
    cyc(1);
    rst = 1'b0;
    bus.unitValid_i = '0;
    chk("midrst_valid", 64'(bus.cdbValid_o), 64'd0);
    bus.unitValid_i = 4'b1010;
    bus.cdbReady_i = 1'b1;
    #2 chk("midrst_ptr", 64'(bus.canGo_o), 64'b0010);
    cyc(3);
    chk("midrst_drain", 64'(bus.cdbValid_o), 64'd0);
`ifdef EXEC_CDB_PERF_CNT_EN
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bus.unitValid_i = 4'b0001;
    cyc(1);
    bus.unitValid_i = 4'b0110;
    bus.cdbReady_i = 1'b0;
    cyc(2);
    bus.cdbReady_i = 1'b1;
    cyc(1);
    bus.unitValid_i = '0;
    chk("perf_conflict", 64'(perf_conf), 64'd3);
    chk("perf_stall", 64'(perf_stall), 64'd2);
`endif
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
